oqpsk_chip_slicer: RTL

Sits directly downstream of the half-sine matched filter in the ZigBee O-QPSK decoder. It takes the filtered 4-bit I/Q samples and acquires the chip timing phase by accumulating I-branch magnitude per sampling phase. It then makes hard chip decisions, I and Q alternately offset by half a period. The serial chip stream it produces feeds the chip-to-symbol despreader.

---
 rtl/oqpsk_chip_slicer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/oqpsk_chip_slicer.sv
// O-QPSK chip slicer: acquires the I-chip sampling phase by per-phase |I| energy,
// then emits alternating hard I/Q chip decisions at the selected phase.
module oqpsk_phase_acc #(
    parameter int ACC_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic [3:0]       mag,
    output logic [ACC_W-1:0] acc
);
    logic [ACC_W:0] sum;

    assign sum = {1'b0, acc} + (ACC_W+1)'(mag);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || clr)
            acc <= '0;
        else if (add_en)
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end
endmodule

module oqpsk_chip_slicer #(
    parameter int SPS         = 8,
    parameter int ACQ_PERIODS = 32,
    parameter int ACC_W       = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_restart,
    input  logic                    i_sample_ready,
    input  logic [3:0]              i_I_postfilter,
    input  logic [3:0]              i_Q_postfilter,
    output logic                    o_chip,
    output logic                    o_chip_valid,
    output logic                    o_chip_is_q,
    output logic                    o_locked,
    output logic [$clog2(SPS)-1:0]  o_phase
);
    localparam int PW = $clog2(SPS);
    localparam logic [PW-1:0] PH_LAST = PW'(SPS - 1);

    typedef enum logic [1:0] {ACQUIRE, SELECT, TRACK} state_t;
    state_t state, state_nxt;

    logic                        take;
    logic [PW-1:0]               ph, sel_idx, best_idx, q_phase;
    logic [PW:0]                 q_sum;
    logic [7:0]                  per_cnt, per_nxt;
    logic [SPS-1:0][ACC_W-1:0]   acc;
    logic [ACC_W-1:0]            best_val;
    logic [3:0]                  i_mag;
    logic                        acq_done, sel_better, sel_last;
    logic                        unused_q;

    // A sample coinciding with restart is dropped entirely.
    assign take       = i_sample_ready & ~i_restart;
    assign i_mag      = i_I_postfilter[3] ? (~i_I_postfilter + 4'd1) : i_I_postfilter;
    assign per_nxt    = per_cnt + 8'd1;
    assign acq_done   = (state == ACQUIRE) && take && (ph == PH_LAST) &&
                        (per_nxt == 8'(ACQ_PERIODS));
    assign sel_better = (sel_idx == '0) || (acc[sel_idx] > best_val);
    assign sel_last   = (sel_idx == PH_LAST);
    assign q_sum      = {1'b0, o_phase} + (PW+1)'(SPS / 2);
    assign q_phase    = (q_sum >= (PW+1)'(SPS)) ? PW'(q_sum - (PW+1)'(SPS)) : q_sum[PW-1:0];
    assign unused_q   = ^i_Q_postfilter[2:0];

    for (genvar k = 0; k < SPS; k++) begin : g_acc
        oqpsk_phase_acc #(.ACC_W(ACC_W)) u_acc (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .clr     (i_restart),
            .add_en  ((state == ACQUIRE) && take && (ph == PW'(k))),
            .mag     (i_mag),
            .acc     (acc[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= ACQUIRE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_restart)
            state_nxt = ACQUIRE;
        else begin
            unique case (state)
                ACQUIRE: if (acq_done) state_nxt = SELECT;
                SELECT:  if (sel_last) state_nxt = TRACK;
                TRACK:   state_nxt = TRACK;
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ph           <= '0;
            per_cnt      <= '0;
            sel_idx      <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            o_chip       <= 1'b0;
            o_chip_valid <= 1'b0;
            o_chip_is_q  <= 1'b0;
            o_locked     <= 1'b0;
            o_phase      <= '0;
        end else begin
            o_chip_valid <= 1'b0;
            if (i_restart) begin
                ph       <= '0;
                per_cnt  <= '0;
                sel_idx  <= '0;
                o_locked <= 1'b0;
            end else begin
                if (i_sample_ready)
                    ph <= (ph == PH_LAST) ? '0 : ph + PW'(1);
                unique case (state)
                    ACQUIRE: begin
                        sel_idx <= '0;
                        if (take && ph == PH_LAST)
                            per_cnt <= per_nxt;
                    end
                    SELECT: begin
                        // Strictly-greater replace keeps ties on the lowest index.
                        if (sel_better) begin
                            best_val <= acc[sel_idx];
                            best_idx <= sel_idx;
                        end
                        sel_idx <= sel_idx + PW'(1);
                        if (sel_last) begin
                            o_phase  <= sel_better ? sel_idx : best_idx;
                            o_locked <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (i_sample_ready && ph == o_phase) begin
                            o_chip_valid <= 1'b1;
                            o_chip       <= ~i_I_postfilter[3];
                            o_chip_is_q  <= 1'b0;
                        end else if (i_sample_ready && ph == q_phase) begin
                            o_chip_valid <= 1'b1;
                            o_chip       <= ~i_Q_postfilter[3];
                            o_chip_is_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
